ptr_bank: RTL
=============

Name: ptr_bank

Overview:
- Multi-channel pointer register file, parametrised successor to the single static-pointer incrementer.
- Holds CHANNELS independent WIDTH-bit offset pointers, each with a programmable upper limit and a wrap/saturate mode, plus a sticky overflow flag per channel.
- Sits beside the segment registers. Control issues commands through a valid/ready port; datapath units bump pointers through a per-channel increment strobe vector.

Parameters:
- WIDTH, 20: pointer/limit width in bits.
- CHANNELS, 4: number of pointer channels (>=2).
- CH_W, 2: channel-select width; CHANNELS <= 2**CH_W.
- STEP_W, 8: width of the signed ADD step taken from cmd_data[STEP_W-1:0].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block accepts a command this cycle.
- cmd_op  in  3  0 NOP, 1 INC, 2 DEC, 3 ADD, 4 LOAD, 5 SETLIM, 6 SETMODE, 7 CLRALL.
- cmd_ch  in  CH_W  target channel.
- cmd_data  in  WIDTH  LOAD value / SETLIM limit / ADD step (low STEP_W bits, signed) / SETMODE bit0 (0 wrap, 1 saturate).
- inc_vec  in  CHANNELS  per-channel +1 strobe.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  read channel.
- rd_valid  out  1  read data valid.
- rd_data  out  WIDTH  pointer value read.
- rd_limit  out  WIDTH  limit of channel read.
- ovf  out  CHANNELS  sticky overflow flags.

Behaviour:
- Reset (async, reset=0):
  - All pointers 0; all limits 2**WIDTH-1; all modes wrap; ovf 0.
  - rd_valid 0; rd_data 0; rd_limit 0; cmd_ready 1; FSM in IDLE.
- Command handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - Effects are visible on the next cycle, so latency is 1.
  - cmd_ch >= CHANNELS: command accepted and ignored.
- Arithmetic:
  - Computed in WIDTH+2 signed bits. The candidate is p+1 (INC / inc_vec), p-1 (DEC) or p+sext(step) (ADD).
  - In range [0, limit]: stored as is.
  - Wrap mode: candidate > limit stores candidate-(limit+1); candidate < 0 stores candidate+(limit+1). ovf[ch] is set in both cases.
  - Wrap mode, ADD with |step| > limit+1: pointer unchanged, ovf set.
  - Saturate mode: clamp to limit or 0, and set ovf only when a clamp actually occurs.
- LOAD: value > limit stores limit and sets ovf; otherwise stores value.
- SETLIM: writes the limit. If the current pointer exceeds the new limit, the pointer is forced to the new limit and ovf is set.
- SETMODE: writes the mode bit only.
- CLRALL:
  - FSM goes IDLE -> SWEEP, and cmd_ready drops the cycle after acceptance.
  - The sweep clears one channel per cycle, in order 0..CHANNELS-1: pointer 0, ovf 0. Limit and mode are kept.
  - Returns to IDLE after the last channel, so cmd_ready is low for exactly CHANNELS cycles.
  - inc_vec is ignored on all channels during SWEEP.
- ovf is sticky. It is cleared only by reset or CLRALL. Setting and clearing never collide, because no commands run during SWEEP.
- inc_vec:
  - Each set bit applies INC semantics (mode/limit aware) to its channel every cycle.
  - Channels not targeted by an accepted command update in parallel.
  - Accepted command and inc_vec on the same channel in the same cycle: the command wins and that cycle's strobe is dropped (documented loss).
- Read port:
  - rd_en registered, so rd_valid asserts 1 cycle later with rd_data/rd_limit sampled at the rd_en edge.
  - A read colliding with an update on the same edge returns the pre-update value.
  - rd_ch >= CHANNELS returns 0 with rd_valid=1.
  - rd_data/rd_limit hold their value when rd_en=0. rd_valid is a 1-cycle pulse per request.
  - Reads are served in SWEEP.
- Reset mid-SWEEP: immediate return to reset state. Channels not yet swept take reset values anyway.

Test Plan:
- Reset, then read ch0..3 -> rd_data 0, rd_limit 0xFFFFF, ovf 0000, cmd_ready 1.
- Ch1 SETLIM 9, wrap; LOAD 8; inc_vec[1] for 3 cycles -> reads 9, 0, 1; ovf[1]=1, other flags 0.
- Ch2 SETLIM 100, SETMODE 1, LOAD 95; ADD step 0x0A (+10) -> 100, ovf[2]=1. Then ADD 0xF6 (-10) -> 90. Then LOAD 200 -> 100.
- Ch0 limit 15 wrap, LOAD 3, ADD -5 -> 14, ovf[0]=1. Then ADD with step 100 (>16) -> unchanged 14.
- Same edge on ch3: INC command plus inc_vec[3] -> pointer +1 only. Read issued on that edge -> pre-increment value.
- CLRALL with all ovf set -> cmd_ready low exactly 4 cycles. Afterwards pointers 0, ovf 0, limits/modes preserved. inc_vec during the sweep has no effect.

Source files
------------

// File: rtl/ptr_bank.sv
// Multi-channel pointer register file: per-channel offset pointer, limit, wrap/saturate
// mode and sticky overflow, driven by a command port and a per-channel increment strobe.
module ptr_bank #(
    parameter int WIDTH    = 20,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int STEP_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [CH_W-1:0]     cmd_ch,
    input  logic [WIDTH-1:0]    cmd_data,
    input  logic [CHANNELS-1:0] inc_vec,
    input  logic                rd_en,
    input  logic [CH_W-1:0]     rd_ch,
    output logic                rd_valid,
    output logic [WIDTH-1:0]    rd_data,
    output logic [WIDTH-1:0]    rd_limit,
    output logic [CHANNELS-1:0] ovf,
    output logic                dbg_state
);

    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] ONE       = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] MINUS_ONE = '1;

    localparam logic [2:0] OP_INC     = 3'd1;
    localparam logic [2:0] OP_DEC     = 3'd2;
    localparam logic [2:0] OP_ADD     = 3'd3;
    localparam logic [2:0] OP_LOAD    = 3'd4;
    localparam logic [2:0] OP_SETLIM  = 3'd5;
    localparam logic [2:0] OP_SETMODE = 3'd6;
    localparam logic [2:0] OP_CLRALL  = 3'd7;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

    state_e              state_q;
    logic [CH_W-1:0]     sweep_q;
    logic                ready_q;

    logic [WIDTH-1:0]    ptr_q [CHANNELS];
    logic [WIDTH-1:0]    ptr_d [CHANNELS];
    logic [WIDTH-1:0]    lim_q [CHANNELS];
    logic [WIDTH-1:0]    lim_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q, mode_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;

    logic                rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [WIDTH-1:0]    rd_limit_q, rd_limit_d;

    logic                cmd_acc;
    logic                ch_ok;
    logic signed [SW-1:0] add_step;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are both
    // high; cmd_ready depends only on internal state, never combinationally on cmd_valid.
    assign cmd_acc   = cmd_valid & ready_q;
    assign ch_ok     = (cmd_ch <= CH_W'(CHANNELS - 1));
    assign add_step  = $signed({{(SW-STEP_W){cmd_data[STEP_W-1]}}, cmd_data[STEP_W-1:0]});

    assign cmd_ready = ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_limit  = rd_limit_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    // Returns {overflow, new_pointer}; out-of-range wrap steps larger than the window leave p.
    function automatic logic [WIDTH:0] step_ptr(
        input logic [WIDTH-1:0]     p,
        input logic [WIDTH-1:0]     lim,
        input logic                 sat,
        input logic signed [SW-1:0] delta
    );
        logic signed [SW-1:0] cand;
        logic signed [SW-1:0] lim_s;
        logic signed [SW-1:0] span;
        logic signed [SW-1:0] mag;
        logic signed [SW-1:0] fix;
        logic [WIDTH:0]       res;
        cand  = $signed({2'b00, p}) + delta;
        lim_s = $signed({2'b00, lim});
        span  = lim_s + ONE;
        mag   = delta[SW-1] ? -delta : delta;
        fix   = '0;
        res   = {1'b0, cand[WIDTH-1:0]};
        if (cand[SW-1]) begin
            fix = cand + span;
            if (sat)              res = {1'b1, {WIDTH{1'b0}}};
            else if (mag > span)  res = {1'b1, p};
            else                  res = {1'b1, fix[WIDTH-1:0]};
        end else if (cand > lim_s) begin
            fix = cand - span;
            if (sat)              res = {1'b1, lim};
            else if (mag > span)  res = {1'b1, p};
            else                  res = {1'b1, fix[WIDTH-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        logic [WIDTH:0] res;
        res    = '0;
        mode_d = mode_q;
        ovf_d  = ovf_q;
        for (int c = 0; c < CHANNELS; c++) begin
            ptr_d[c] = ptr_q[c];
            lim_d[c] = lim_q[c];
            res      = '0;
            if (state_q == ST_SWEEP) begin
                if (sweep_q == CH_W'(c)) begin
                    ptr_d[c] = '0;
                    ovf_d[c] = 1'b0;
                end
            end else if (cmd_acc && ch_ok && cmd_ch == CH_W'(c)) begin
                case (cmd_op)
                    OP_INC, OP_DEC, OP_ADD: begin
                        res = step_ptr(ptr_q[c], lim_q[c], mode_q[c],
                                       (cmd_op == OP_INC) ? ONE :
                                       (cmd_op == OP_DEC) ? MINUS_ONE : add_step);
                        ptr_d[c] = res[WIDTH-1:0];
                        ovf_d[c] = ovf_q[c] | res[WIDTH];
                    end
                    OP_LOAD: begin
                        if (cmd_data > lim_q[c]) begin
                            ptr_d[c] = lim_q[c];
                            ovf_d[c] = 1'b1;
                        end else begin
                            ptr_d[c] = cmd_data;
                        end
                    end
                    OP_SETLIM: begin
                        lim_d[c] = cmd_data;
                        if (ptr_q[c] > cmd_data) begin
                            ptr_d[c] = cmd_data;
                            ovf_d[c] = 1'b1;
                        end
                    end
                    OP_SETMODE: mode_d[c] = cmd_data[0];
                    default: ;
                endcase
            end else if (inc_vec[c]) begin
                res      = step_ptr(ptr_q[c], lim_q[c], mode_q[c], ONE);
                ptr_d[c] = res[WIDTH-1:0];
                ovf_d[c] = ovf_q[c] | res[WIDTH];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        rd_limit_d = rd_limit_q;
        if (rd_en) begin
            rd_data_d  = '0;
            rd_limit_d = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (rd_ch == CH_W'(c)) begin
                    rd_data_d  = ptr_q[c];
                    rd_limit_d = lim_q[c];
                end
            end
        end
    end

    // CLRALL sweep: one channel per cycle, ready held low for exactly CHANNELS cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_acc && ch_ok && cmd_op == OP_CLRALL) begin
                        state_q <= ST_SWEEP;
                        sweep_q <= '0;
                        ready_q <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    if (sweep_q == CH_W'(CHANNELS - 1)) begin
                        state_q <= ST_IDLE;
                        sweep_q <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_q[c] <= '0;
                lim_q[c] <= '1;
            end
            mode_q     <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_limit_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                ptr_q[c] <= ptr_d[c];
                lim_q[c] <= lim_d[c];
            end
            mode_q     <= mode_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_limit_q <= rd_limit_d;
        end
    end

endmodule
